// File: rtl/ym_write_arbiter_if.sv
// Signal bundle between the two register-write requesters, the write arbiter
// and the YMF262 host-bus pins.
interface ym_write_arbiter_if;
  logic       req0_valid;
  logic       req0_ready;
  logic       req0_bank;
  logic [7:0] req0_reg;
  logic [7:0] req0_data;

  logic       req1_valid;
  logic       req1_ready;
  logic       req1_bank;
  logic [7:0] req1_reg;
  logic [7:0] req1_data;

  logic [1:0] ym_a;
  logic [7:0] ym_d;
  logic       ym_d_oe;
  logic       ym_cs_n;
  logic       ym_wr_n;
  logic       busy;

  // The arbiter consumes requests and drives the chip pins.
  modport slave (
    input  req0_valid, req0_bank, req0_reg, req0_data,
    input  req1_valid, req1_bank, req1_reg, req1_data,
    output req0_ready, req1_ready,
    output ym_a, ym_d, ym_d_oe, ym_cs_n, ym_wr_n, busy
  );

  modport master (
    output req0_valid, req0_bank, req0_reg, req0_data,
    output req1_valid, req1_bank, req1_reg, req1_data,
    input  req0_ready, req1_ready,
    input  ym_a, ym_d, ym_d_oe, ym_cs_n, ym_wr_n, busy
  );
endinterface

// File: rtl/ym_write_arbiter.sv
// Round-robin YMF262 register-write arbiter: expands each granted write into
// an address cycle and a data cycle with setup, strobe, hold and recovery.
module ym_write_arbiter #(
  parameter int T_SETUP    = 1,
  parameter int T_WR       = 3,
  parameter int T_HOLD     = 1,
  parameter int T_REC_ADDR = 64,
  parameter int T_REC_DATA = 64
) (
  input logic               clk,
  input logic               reset,
  ym_write_arbiter_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, A_SETUP, A_PULSE, A_HOLD, A_REC, D_SETUP, D_PULSE, D_HOLD, D_REC
  } state_t;

  localparam logic [7:0] LEN_SETUP    = 8'(T_SETUP);
  localparam logic [7:0] LEN_WR       = 8'(T_WR);
  localparam logic [7:0] LEN_HOLD     = 8'(T_HOLD);
  localparam logic [7:0] LEN_REC_ADDR = 8'(T_REC_ADDR);
  localparam logic [7:0] LEN_REC_DATA = 8'(T_REC_DATA);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       lastGrant_q, lastGrant_d;
  logic       bank_q, bank_d;
  logic [7:0] reg_q, reg_d;
  logic [7:0] data_q, data_d;
  logic [1:0] ymA_q, ymA_d;
  logic [7:0] ymD_q, ymD_d;
  logic       ymDOe_q, ymDOe_d;
  logic       ymCsN_q, ymCsN_d;
  logic       ymWrN_q, ymWrN_d;

  logic       grant0, grant1;
  logic       accept0, accept1;
  logic       handshake;
  logic       cntDone;
  logic       busCycle;

  function automatic logic [7:0] stateLen(state_t s);
    case (s)
      A_SETUP, D_SETUP: stateLen = LEN_SETUP;
      A_PULSE, D_PULSE: stateLen = LEN_WR;
      A_HOLD,  D_HOLD:  stateLen = LEN_HOLD;
      A_REC:            stateLen = LEN_REC_ADDR;
      D_REC:            stateLen = LEN_REC_DATA;
      default:          stateLen = 8'd0;
    endcase
  endfunction

  // A lone requester always wins; a tie goes to whoever was not served last.
  always_comb begin
    grant0 = bus.req0_valid && (!bus.req1_valid || lastGrant_q);
    grant1 = bus.req1_valid && (!bus.req0_valid || !lastGrant_q);
  end

  assign accept0   = (state_q == IDLE) && !reset && grant0;
  assign accept1   = (state_q == IDLE) && !reset && grant1;
  assign handshake = accept0 || accept1;
  assign cntDone   = (cnt_q == 8'd1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (handshake) state_d = A_SETUP;
      A_SETUP: if (cntDone)   state_d = A_PULSE;
      A_PULSE: if (cntDone)   state_d = A_HOLD;
      A_HOLD:  if (cntDone)   state_d = A_REC;
      A_REC:   if (cntDone)   state_d = D_SETUP;
      D_SETUP: if (cntDone)   state_d = D_PULSE;
      D_PULSE: if (cntDone)   state_d = D_HOLD;
      D_HOLD:  if (cntDone)   state_d = D_REC;
      D_REC:   if (cntDone)   state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = stateLen(state_d);
    end else if (state_q != IDLE && !cntDone) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  // Pin values are derived from the next state so the registered outputs
  // line up exactly with the state they belong to.
  always_comb begin
    lastGrant_d = lastGrant_q;
    bank_d      = bank_q;
    reg_d       = reg_q;
    data_d      = data_q;
    ymA_d       = ymA_q;
    ymD_d       = ymD_q;
    if (handshake) begin
      lastGrant_d = accept1;
      bank_d      = accept1 ? bus.req1_bank : bus.req0_bank;
      reg_d       = accept1 ? bus.req1_reg  : bus.req0_reg;
      data_d      = accept1 ? bus.req1_data : bus.req0_data;
      ymA_d       = {bank_d, 1'b0};
      ymD_d       = reg_d;
    end else if (state_q == A_REC && state_d == D_SETUP) begin
      ymA_d = {bank_q, 1'b1};
      ymD_d = data_q;
    end
    busCycle = state_d inside {A_SETUP, A_PULSE, A_HOLD, D_SETUP, D_PULSE, D_HOLD};
    ymCsN_d  = !busCycle;
    ymDOe_d  = busCycle;
    ymWrN_d  = !(state_d inside {A_PULSE, D_PULSE});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      lastGrant_q <= 1'b1;
      bank_q      <= 1'b0;
      reg_q       <= '0;
      data_q      <= '0;
      ymA_q       <= '0;
      ymD_q       <= '0;
      ymDOe_q     <= 1'b0;
      ymCsN_q     <= 1'b1;
      ymWrN_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lastGrant_q <= lastGrant_d;
      bank_q      <= bank_d;
      reg_q       <= reg_d;
      data_q      <= data_d;
      ymA_q       <= ymA_d;
      ymD_q       <= ymD_d;
      ymDOe_q     <= ymDOe_d;
      ymCsN_q     <= ymCsN_d;
      ymWrN_q     <= ymWrN_d;
    end
  end

  assign bus.req0_ready = accept0;
  assign bus.req1_ready = accept1;
  assign bus.ym_a       = ymA_q;
  assign bus.ym_d       = ymD_q;
  assign bus.ym_d_oe    = ymDOe_q;
  assign bus.ym_cs_n    = ymCsN_q;
  assign bus.ym_wr_n    = ymWrN_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ym_write_arbiter.sv
// Bench for ym_write_arbiter: a default-timing and a short-recovery instance
// are checked every cycle against a write-timeline model of the bus.
module tb_ym_write_arbiter;
  localparam int NI  = 2;
  localparam int S   = 1;
  localparam int W   = 3;
  localparam int H   = 1;
  localparam int P   = S + W + H;
  localparam int RA0 = 64;
  localparam int RD0 = 64;
  localparam int RA1 = 10;
  localparam int RD1 = 20;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ym_write_arbiter_if bus0();
  ym_write_arbiter_if bus1();

  ym_write_arbiter dutDef (.clk(clk), .reset(reset), .bus(bus0.slave));
  ym_write_arbiter #(.T_REC_ADDR(RA1), .T_REC_DATA(RD1)) dutGap (.clk(clk), .reset(reset), .bus(bus1.slave));

  logic       reqValid [NI][2];
  logic       reqBank  [NI][2];
  logic [7:0] reqReg   [NI][2];
  logic [7:0] reqData  [NI][2];
  logic       obsReady [NI][2];
  logic [1:0] obsA     [NI];
  logic [7:0] obsD     [NI];
  logic       obsOe    [NI];
  logic       obsCs    [NI];
  logic       obsWr    [NI];
  logic       obsBusy  [NI];

  assign bus0.req0_valid = reqValid[0][0];
  assign bus0.req0_bank  = reqBank[0][0];
  assign bus0.req0_reg   = reqReg[0][0];
  assign bus0.req0_data  = reqData[0][0];
  assign bus0.req1_valid = reqValid[0][1];
  assign bus0.req1_bank  = reqBank[0][1];
  assign bus0.req1_reg   = reqReg[0][1];
  assign bus0.req1_data  = reqData[0][1];
  assign bus1.req0_valid = reqValid[1][0];
  assign bus1.req0_bank  = reqBank[1][0];
  assign bus1.req0_reg   = reqReg[1][0];
  assign bus1.req0_data  = reqData[1][0];
  assign bus1.req1_valid = reqValid[1][1];
  assign bus1.req1_bank  = reqBank[1][1];
  assign bus1.req1_reg   = reqReg[1][1];
  assign bus1.req1_data  = reqData[1][1];

  assign obsReady[0][0] = bus0.req0_ready;
  assign obsReady[0][1] = bus0.req1_ready;
  assign obsReady[1][0] = bus1.req0_ready;
  assign obsReady[1][1] = bus1.req1_ready;
  assign obsA[0]    = bus0.ym_a;
  assign obsA[1]    = bus1.ym_a;
  assign obsD[0]    = bus0.ym_d;
  assign obsD[1]    = bus1.ym_d;
  assign obsOe[0]   = bus0.ym_d_oe;
  assign obsOe[1]   = bus1.ym_d_oe;
  assign obsCs[0]   = bus0.ym_cs_n;
  assign obsCs[1]   = bus1.ym_cs_n;
  assign obsWr[0]   = bus0.ym_wr_n;
  assign obsWr[1]   = bus1.ym_wr_n;
  assign obsBusy[0] = bus0.busy;
  assign obsBusy[1] = bus1.busy;

  int         passChecks;
  int         totalChecks;
  int         edgeCnt;
  bit         randMode;
  int         budget   [NI][2];
  bit         accepted [NI][2];
  bit         expRdy   [NI][2];
  bit         dutHs    [NI][2];

  bit         mActive [NI];
  bit         mEver   [NI];
  bit         mLast   [NI];
  int         mStart  [NI];
  logic       mBank   [NI];
  logic [7:0] mReg    [NI];
  logic [7:0] mData   [NI];

  int         hsNum    [NI];
  int         grantSeq [NI][16];
  int         hsEdge   [NI][16];
  int         busyCnt  [NI];
  int         recCnt   [NI];
  int         wrLowCnt [NI];

  function automatic int recA(int i);
    return (i == 0) ? RA0 : RA1;
  endfunction

  function automatic int lenOf(int i);
    return 2 * P + recA(i) + ((i == 0) ? RD0 : RD1);
  endfunction

  task automatic checkOutput(string tag, int inst, logic [31:0] obs, logic [31:0] exp);
    totalChecks++;
    assert (obs === exp) passChecks++;
    else $error("[TB] FAIL %s inst=%0d observed=%0h expected=%0h edge=%0d", tag, inst, obs, exp, edgeCnt);
  endtask

  task automatic modelReset(int i);
    mActive[i] = 1'b0;
    mEver[i]   = 1'b0;
    mLast[i]   = 1'b1;
  endtask

  task automatic clearLog();
    for (int i = 0; i < NI; i++) begin
      hsNum[i] = 0; busyCnt[i] = 0; recCnt[i] = 0; wrLowCnt[i] = 0;
    end
  endtask

  // Expected pins follow from the cycle offset since the last handshake.
  task automatic checkAll();
    for (int i = 0; i < NI; i++) begin
      int t, u;
      bit act;
      logic expCs, expWr, expOe;
      logic [1:0] expA;
      logic [7:0] expD;
      t = edgeCnt - mStart[i];
      act = mActive[i] && (t < lenOf(i));
      expCs = 1'b1; expWr = 1'b1; expOe = 1'b0;
      if (act) begin
        u = -1;
        if (t < P) u = t;
        else if (t >= P + recA(i) && t < 2 * P + recA(i)) u = t - P - recA(i);
        if (u >= 0) begin
          expCs = 1'b0; expOe = 1'b1;
          expWr = !(u >= S && u < S + W);
        end
      end
      if (!mEver[i]) begin
        expA = 2'b00; expD = 8'h00;
      end else if (t < P + recA(i)) begin
        expA = {mBank[i], 1'b0}; expD = mReg[i];
      end else begin
        expA = {mBank[i], 1'b1}; expD = mData[i];
      end
      expRdy[i][0] = !act && !reset && reqValid[i][0] && (!reqValid[i][1] || mLast[i]);
      expRdy[i][1] = !act && !reset && reqValid[i][1] && (!reqValid[i][0] || !mLast[i]);
      checkOutput("ym_cs_n", i, 32'(obsCs[i]), 32'(expCs));
      checkOutput("ym_wr_n", i, 32'(obsWr[i]), 32'(expWr));
      checkOutput("ym_d_oe", i, 32'(obsOe[i]), 32'(expOe));
      checkOutput("ym_a", i, 32'(obsA[i]), 32'(expA));
      checkOutput("ym_d", i, 32'(obsD[i]), 32'(expD));
      checkOutput("busy", i, 32'(obsBusy[i]), 32'(act));
      checkOutput("req0_ready", i, 32'(obsReady[i][0]), 32'(expRdy[i][0]));
      checkOutput("req1_ready", i, 32'(obsReady[i][1]), 32'(expRdy[i][1]));
      for (int n = 0; n < 2; n++) dutHs[i][n] = (obsReady[i][n] === 1'b1) && reqValid[i][n];
      if (obsBusy[i] === 1'b1) busyCnt[i]++;
      if (obsBusy[i] === 1'b1 && obsCs[i] === 1'b1) recCnt[i]++;
      if (obsWr[i] === 1'b0) wrLowCnt[i]++;
    end
  endtask

  task automatic modelEdge();
    edgeCnt++;
    for (int i = 0; i < NI; i++) begin
      for (int n = 0; n < 2; n++) begin
        if (!reset && expRdy[i][n] && reqValid[i][n]) begin
          mActive[i] = 1'b1; mEver[i] = 1'b1; mStart[i] = edgeCnt;
          mBank[i] = reqBank[i][n]; mReg[i] = reqReg[i][n]; mData[i] = reqData[i][n];
          mLast[i] = (n == 1);
          accepted[i][n] = 1'b1;
        end
        if (dutHs[i][n]) begin
          if (hsNum[i] < 16) begin
            grantSeq[i][hsNum[i]] = n;
            hsEdge[i][hsNum[i]]   = edgeCnt;
          end
          hsNum[i]++;
          dutHs[i][n] = 1'b0;
        end
      end
    end
  endtask

  task automatic newFields(int i, int n);
    reqBank[i][n] = 1'($urandom_range(0, 1));
    reqReg[i][n]  = 8'($urandom);
    reqData[i][n] = 8'($urandom);
  endtask

  task automatic applyStimulus();
    for (int i = 0; i < NI; i++) begin
      for (int n = 0; n < 2; n++) begin
        if (accepted[i][n]) begin
          accepted[i][n] = 1'b0;
          budget[i][n]--;
          if (budget[i][n] > 0 && !randMode) newFields(i, n);
          else reqValid[i][n] = 1'b0;
        end else if (randMode) begin
          if (!reqValid[i][n] && budget[i][n] > 0 && $urandom_range(0, 7) == 0) begin
            reqValid[i][n] = 1'b1;
            newFields(i, n);
          end else if (reqValid[i][n] && $urandom_range(0, 31) == 0) begin
            reqValid[i][n] = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic run(int cycles);
    repeat (cycles) begin
      @(negedge clk);
      checkAll();
      @(posedge clk);
      modelEdge();
      #1;
      applyStimulus();
    end
  endtask

  task automatic resetAssert();
    reset = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      checkOutput("rst.ym_cs_n", i, 32'(obsCs[i]), 32'd1);
      checkOutput("rst.ym_wr_n", i, 32'(obsWr[i]), 32'd1);
      checkOutput("rst.ym_d_oe", i, 32'(obsOe[i]), 32'd0);
      checkOutput("rst.ym_a", i, 32'(obsA[i]), 32'd0);
      checkOutput("rst.ym_d", i, 32'(obsD[i]), 32'd0);
      checkOutput("rst.busy", i, 32'(obsBusy[i]), 32'd0);
      checkOutput("rst.ready0", i, 32'(obsReady[i][0]), 32'd0);
      checkOutput("rst.ready1", i, 32'(obsReady[i][1]), 32'd0);
      modelReset(i);
    end
  endtask

  initial begin
    passChecks = 0; totalChecks = 0; edgeCnt = 0; randMode = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < NI; i++) begin
      for (int n = 0; n < 2; n++) begin
        reqValid[i][n] = 1'b0; reqBank[i][n] = 1'b0; reqReg[i][n] = '0; reqData[i][n] = '0;
        budget[i][n] = 0; accepted[i][n] = 1'b0; expRdy[i][n] = 1'b0; dutHs[i][n] = 1'b0;
      end
      mStart[i] = 0; mBank[i] = 1'b0; mReg[i] = '0; mData[i] = '0;
      modelReset(i);
    end
    clearLog();
    #2;
    resetAssert();
    run(2);
    reset = 1'b0;
    run(2);

    $display("[TB] single write from req0");
    clearLog();
    for (int i = 0; i < NI; i++) begin
      reqValid[i][0] = 1'b1; reqBank[i][0] = 1'b1; reqReg[i][0] = 8'h05; reqData[i][0] = 8'h03;
      budget[i][0] = 1;
    end
    run(lenOf(0) + 4);
    for (int i = 0; i < NI; i++) begin
      checkOutput("single.grants", i, 32'(hsNum[i]), 32'd1);
      checkOutput("single.busyCycles", i, 32'(busyCnt[i]), 32'(lenOf(i)));
      checkOutput("single.recCycles", i, 32'(recCnt[i]), 32'(recA(i) + ((i == 0) ? RD0 : RD1)));
      checkOutput("single.wrLowCycles", i, 32'(wrLowCnt[i]), 32'(2 * W));
    end

    $display("[TB] both requesters valid from reset release");
    resetAssert();
    for (int i = 0; i < NI; i++) begin
      for (int n = 0; n < 2; n++) begin
        reqValid[i][n] = 1'b1; newFields(i, n); budget[i][n] = 3;
      end
    end
    run(1);
    reset = 1'b0;
    clearLog();
    run(6 * (lenOf(0) + 1) + 4);
    for (int i = 0; i < NI; i++) begin
      checkOutput("alt.grants", i, 32'(hsNum[i]), 32'd6);
      for (int j = 0; j < 6; j++) checkOutput("alt.order", i, 32'(grantSeq[i][j]), 32'(j % 2));
      for (int j = 1; j < 6; j++)
        checkOutput("alt.spacing", i, 32'(hsEdge[i][j] - hsEdge[i][j-1]), 32'(lenOf(i) + 1));
    end

    $display("[TB] req1 alone, three writes back to back");
    clearLog();
    for (int i = 0; i < NI; i++) begin
      reqValid[i][1] = 1'b1; newFields(i, 1); budget[i][1] = 3;
    end
    run(3 * (lenOf(0) + 1) + 4);
    for (int i = 0; i < NI; i++) begin
      checkOutput("solo.grants", i, 32'(hsNum[i]), 32'd3);
      for (int j = 0; j < 3; j++) checkOutput("solo.who", i, 32'(grantSeq[i][j]), 32'd1);
    end

    $display("[TB] reset during address strobe");
    clearLog();
    for (int i = 0; i < NI; i++) begin
      reqValid[i][0] = 1'b1; newFields(i, 0); budget[i][0] = 1;
    end
    run(2);
    for (int i = 0; i < NI; i++) checkOutput("abort.wrLow", i, 32'(obsWr[i]), 32'd0);
    for (int i = 0; i < NI; i++) begin
      reqValid[i][1] = 1'b1; newFields(i, 1); budget[i][1] = 1;
    end
    resetAssert();
    run(1);
    reset = 1'b0;
    clearLog();
    run(lenOf(0) + 4);
    for (int i = 0; i < NI; i++) begin
      checkOutput("abort.grants", i, 32'(hsNum[i]), 32'd1);
      checkOutput("abort.who", i, 32'(grantSeq[i][0]), 32'd1);
      checkOutput("abort.busyCycles", i, 32'(busyCnt[i]), 32'(lenOf(i)));
    end

    $display("[TB] short req0 pulse while busy");
    clearLog();
    for (int i = 0; i < NI; i++) begin
      reqValid[i][1] = 1'b1; newFields(i, 1); budget[i][1] = 1;
    end
    run(6);
    for (int i = 0; i < NI; i++) begin
      reqValid[i][0] = 1'b1; newFields(i, 0); budget[i][0] = 1;
    end
    run(1);
    for (int i = 0; i < NI; i++) begin
      reqValid[i][0] = 1'b0; budget[i][0] = 0;
    end
    run(lenOf(0) + 4);
    for (int i = 0; i < NI; i++) begin
      checkOutput("pulse.grants", i, 32'(hsNum[i]), 32'd1);
      checkOutput("pulse.who", i, 32'(grantSeq[i][0]), 32'd1);
      checkOutput("pulse.busyCycles", i, 32'(busyCnt[i]), 32'(lenOf(i)));
    end

    $display("[TB] randomized traffic");
    randMode = 1'b1;
    for (int i = 0; i < NI; i++) begin
      budget[i][0] = 1000; budget[i][1] = 1000;
    end
    run(1200);
    randMode = 1'b0;
    for (int i = 0; i < NI; i++) begin
      for (int n = 0; n < 2; n++) begin
        reqValid[i][n] = 1'b0; budget[i][n] = 0;
      end
    end
    run(lenOf(0) + 4);
    for (int i = 0; i < NI; i++) checkOutput("drain.busy", i, 32'(obsBusy[i]), 32'd0);

    $display("%0d/%0d checks passed", passChecks, totalChecks);
    $finish;
  end
endmodule
